// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage: next-PC selection, 1-cycle synchronous instruction SRAM
// request, IF register with skid buffer, and valid/allowin handoff to decode.
module if_stage_pipe #(
    parameter logic [31:0] RESET_PC  = 32'h1c00_0000,
    parameter logic        ALIGN_CHK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        fs_to_ds_valid,
    output logic [64:0] fs_to_ds_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    logic        to_fs_valid_s;
    logic        fs_ready_go_s;
    logic        fs_allowin_s;
    logic        pre_adef_s;
    logic        buf_cap_s;
    logic [31:0] seq_pc_s;
    logic [31:0] nextpc_s;
    logic [31:0] fs_inst_s;

    logic        fs_valid_r;
    logic        fs_adef_r;
    logic [31:0] fs_pc_r;
    logic        buf_valid_r;
    logic [31:0] inst_buf_r;

    // Next-PC select: flush beats branch, branch beats sequential fetch
    always_comb begin
        seq_pc_s = fs_pc_r + 32'd4;
        if (flush) begin
            nextpc_s = flush_target;
        end else if (br_taken) begin
            nextpc_s = br_target;
        end else begin
            nextpc_s = seq_pc_s;
        end
    end

    assign to_fs_valid_s = ~reset;
    assign fs_ready_go_s = 1'b1;
    assign pre_adef_s    = ALIGN_CHK & (nextpc_s[1:0] != 2'b00);
    assign fs_allowin_s  = ~fs_valid_r | (fs_ready_go_s & ds_allowin) | flush;
    // SRAM data is only valid for one cycle, so grab it on the first stalled cycle
    assign buf_cap_s     = fs_valid_r & ~ds_allowin & ~buf_valid_r & ~flush;

    // IF register: loads whenever the stage can accept a new fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_r <= 1'b0;
            fs_pc_r    <= RESET_PC - 32'd4;
            fs_adef_r  <= 1'b0;
        end else if (fs_allowin_s) begin
            fs_valid_r <= to_fs_valid_s;
            fs_pc_r    <= nextpc_s;
            fs_adef_r  <= pre_adef_s;
        end
    end

    // Skid buffer holding the fetched word across a decode stall
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_r <= 1'b0;
            inst_buf_r  <= 32'h0000_0000;
        end else if (fs_allowin_s) begin
            buf_valid_r <= 1'b0;
        end else if (buf_cap_s) begin
            buf_valid_r <= 1'b1;
            inst_buf_r  <= inst_sram_rdata;
        end
    end

    // Instruction select: faulting fetches carry a zero word
    always_comb begin
        if (fs_adef_r) begin
            fs_inst_s = 32'h0000_0000;
        end else if (buf_valid_r) begin
            fs_inst_s = inst_buf_r;
        end else begin
            fs_inst_s = inst_sram_rdata;
        end
    end

    assign fs_to_ds_valid  = fs_valid_r & fs_ready_go_s & ~flush & ~br_taken;
    assign fs_to_ds_bus    = {fs_adef_r, fs_pc_r, fs_inst_s};
    assign inst_sram_en    = to_fs_valid_s & fs_allowin_s & ~pre_adef_s;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = nextpc_s;
    assign inst_sram_wdata = 32'h0000_0000;

endmodule

// File: tb/tb_if_stage_pipe.sv
// Scoreboard bench for if_stage_pipe: expected decode handoffs are queued as stimulus
// is driven and compared as each transfer occurs; a second instance runs with ALIGN_CHK=0.
module tb_if_stage_pipe;

    logic        clk;
    logic        reset;
    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] flush_target;

    logic        fs_to_ds_valid, fs_to_ds_valid_b;
    logic [64:0] fs_to_ds_bus, fs_to_ds_bus_b;
    logic        inst_sram_en, inst_sram_en_b;
    logic [3:0]  inst_sram_we, inst_sram_we_b;
    logic [31:0] inst_sram_addr, inst_sram_addr_b;
    logic [31:0] inst_sram_wdata, inst_sram_wdata_b;
    logic [31:0] inst_sram_rdata, inst_sram_rdata_b;

    logic [64:0] exp_q[$];
    logic [64:0] exp_e;
    int tests;
    int fails;

    if_stage_pipe dut (
        .clk(clk), .reset(reset), .ds_allowin(ds_allowin),
        .br_taken(br_taken), .br_target(br_target),
        .flush(flush), .flush_target(flush_target),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata)
    );

    if_stage_pipe #(.ALIGN_CHK(1'b0)) dut_na (
        .clk(clk), .reset(reset), .ds_allowin(ds_allowin),
        .br_taken(br_taken), .br_target(br_target),
        .flush(flush), .flush_target(flush_target),
        .fs_to_ds_valid(fs_to_ds_valid_b), .fs_to_ds_bus(fs_to_ds_bus_b),
        .inst_sram_en(inst_sram_en_b), .inst_sram_we(inst_sram_we_b),
        .inst_sram_addr(inst_sram_addr_b), .inst_sram_wdata(inst_sram_wdata_b),
        .inst_sram_rdata(inst_sram_rdata_b)
    );

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        return a ^ 32'h5a5a_0ff0;
    endfunction

    function automatic logic [64:0] exp_bus(input logic adef, input logic [31:0] pc);
        return {adef, pc, (adef ? 32'h0000_0000 : sram_word(pc))};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: 1-cycle read, output not held when idle
    always @(posedge clk) begin
        inst_sram_rdata   <= inst_sram_en   ? sram_word(inst_sram_addr)   : 32'hdead_beef;
        inst_sram_rdata_b <= inst_sram_en_b ? sram_word(inst_sram_addr_b) : 32'hdead_beef;
    end

    // Branch redirects are only legal while decode accepts, unless a flush overrides
    always @(posedge clk) begin
        if (!reset) assert (!(br_taken && !ds_allowin && !flush))
            else $error("br_taken asserted while ds_allowin=0 without flush");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        if (!reset && fs_to_ds_valid && ds_allowin) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got %h required no transfer", fs_to_ds_bus);
            end else begin
                exp_e = exp_q.pop_front();
                if (fs_to_ds_bus !== exp_e) begin
                    fails++;
                    $display("FAIL sb_bus: got %h required %h", fs_to_ds_bus, exp_e);
                end
            end
        end
    endtask

    task automatic end_test(input string name);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_sb_left: got %0d pending required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic apply_reset();
        cyc();
        reset = 1'b1; ds_allowin = 1'b1; br_taken = 1'b0; flush = 1'b0;
        br_target = 32'h0; flush_target = 32'h0;
        for (int i = 0; i < 2; i++) begin
            smp();
            tests++;
            if (inst_sram_en !== 1'b0) begin
                fails++; $display("FAIL rst_en: got %b required 0", inst_sram_en);
            end
            cyc();
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0000));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0004));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0008));
        smp();
        tests++;
        if ({inst_sram_en, fs_to_ds_valid, inst_sram_addr} !== {1'b1, 1'b0, 32'h1c00_0000}) begin
            fails++; $display("FAIL rst_first: got en=%b v=%b addr=%h required 1 0 1c000000",
                              inst_sram_en, fs_to_ds_valid, inst_sram_addr);
        end
        cyc(); smp();
        tests++;
        if ({fs_to_ds_valid, inst_sram_addr} !== {1'b1, 32'h1c00_0004}) begin
            fails++; $display("FAIL rst_second: got v=%b addr=%h required 1 1c000004",
                              fs_to_ds_valid, inst_sram_addr);
        end
        cyc(); smp();
        tests++;
        if (inst_sram_addr !== 32'h1c00_0008) begin
            fails++; $display("FAIL rst_third: got %h required 1c000008", inst_sram_addr);
        end
        cyc(); smp();
        end_test("reset");
    endtask

    task automatic test_stall();
        apply_reset();
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0000));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0004));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0008));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_000c));
        smp(); cyc(); smp(); cyc(); smp();
        cyc();
        ds_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            tests++;
            if ({inst_sram_en, fs_to_ds_valid, fs_to_ds_bus[63:0]} !==
                {1'b0, 1'b1, 32'h1c00_0008, sram_word(32'h1c00_0008)}) begin
                fails++; $display("FAIL stall_hold%0d: got en=%b v=%b bus=%h", i,
                                  inst_sram_en, fs_to_ds_valid, fs_to_ds_bus);
            end
            if (i < 2) cyc();
        end
        cyc();
        ds_allowin = 1'b1;
        smp();
        tests++;
        if ({inst_sram_en, inst_sram_addr} !== {1'b1, 32'h1c00_000c}) begin
            fails++; $display("FAIL stall_release: got en=%b addr=%h required 1 1c00000c",
                              inst_sram_en, inst_sram_addr);
        end
        cyc(); smp();
        end_test("stall");
    endtask

    task automatic test_branch();
        apply_reset();
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0000));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0004));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0008));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_000c));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0100));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0104));
        smp();
        for (int i = 0; i < 4; i++) begin
            cyc(); smp();
        end
        cyc();
        br_taken = 1'b1; br_target = 32'h1c00_0100;
        smp();
        tests++;
        if ({fs_to_ds_valid, inst_sram_en, inst_sram_addr, fs_to_ds_bus[63:32]} !==
            {1'b0, 1'b1, 32'h1c00_0100, 32'h1c00_0010}) begin
            fails++; $display("FAIL br_redirect: got v=%b en=%b addr=%h pc=%h",
                              fs_to_ds_valid, inst_sram_en, inst_sram_addr, fs_to_ds_bus[63:32]);
        end
        cyc();
        br_taken = 1'b0;
        smp(); cyc(); smp();
        end_test("branch");
    endtask

    task automatic test_flush();
        apply_reset();
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0000));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0004));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_8000));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_8004));
        smp(); cyc(); smp(); cyc(); smp();
        cyc();
        ds_allowin = 1'b0;
        smp();
        cyc();
        flush = 1'b1; flush_target = 32'h1c00_8000;
        br_taken = 1'b1; br_target = 32'h1c00_0100;
        smp();
        tests++;
        if ({dut.buf_valid_r, fs_to_ds_valid, inst_sram_en, inst_sram_addr} !==
            {1'b1, 1'b0, 1'b1, 32'h1c00_8000}) begin
            fails++; $display("FAIL flush_redirect: got buf=%b v=%b en=%b addr=%h",
                              dut.buf_valid_r, fs_to_ds_valid, inst_sram_en, inst_sram_addr);
        end
        cyc();
        flush = 1'b0; br_taken = 1'b0; ds_allowin = 1'b1;
        smp();
        tests++;
        if (dut.buf_valid_r !== 1'b0) begin
            fails++; $display("FAIL flush_buf_clr: got %b required 0", dut.buf_valid_r);
        end
        cyc(); smp();
        end_test("flush");
    endtask

    task automatic test_align();
        apply_reset();
        exp_q.push_back(exp_bus(1'b1, 32'h1c00_0102));
        exp_q.push_back(exp_bus(1'b1, 32'h1c00_0106));
        smp();
        cyc();
        br_taken = 1'b1; br_target = 32'h1c00_0102;
        smp();
        tests++;
        if ({inst_sram_en, inst_sram_addr, inst_sram_en_b, inst_sram_addr_b} !==
            {1'b0, 32'h1c00_0102, 1'b1, 32'h1c00_0102}) begin
            fails++; $display("FAIL align_req: got en=%b addr=%h en_nochk=%b addr_nochk=%h",
                              inst_sram_en, inst_sram_addr, inst_sram_en_b, inst_sram_addr_b);
        end
        cyc();
        br_taken = 1'b0;
        smp();
        tests++;
        if ({fs_to_ds_valid_b, fs_to_ds_bus_b} !== {1'b1, exp_bus(1'b0, 32'h1c00_0102)}) begin
            fails++; $display("FAIL noalign_bus: got v=%b bus=%h required 1 %h",
                              fs_to_ds_valid_b, fs_to_ds_bus_b, exp_bus(1'b0, 32'h1c00_0102));
        end
        tests++;
        if (inst_sram_en !== 1'b0) begin
            fails++; $display("FAIL align_en2: got %b required 0", inst_sram_en);
        end
        cyc(); smp();
        tests++;
        if (fs_to_ds_bus_b !== exp_bus(1'b0, 32'h1c00_0106)) begin
            fails++; $display("FAIL noalign_bus2: got %h required %h",
                              fs_to_ds_bus_b, exp_bus(1'b0, 32'h1c00_0106));
        end
        end_test("align");
    endtask

    task automatic test_reset_stall();
        apply_reset();
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0000));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0004));
        exp_q.push_back(exp_bus(1'b0, 32'h1c00_0000));
        smp(); cyc(); smp(); cyc(); smp();
        cyc();
        ds_allowin = 1'b0;
        smp();
        cyc();
        reset = 1'b1;
        smp();
        tests++;
        if ({dut.buf_valid_r, inst_sram_en} !== {1'b1, 1'b0}) begin
            fails++; $display("FAIL rststall_pre: got buf=%b en=%b required 1 0",
                              dut.buf_valid_r, inst_sram_en);
        end
        cyc();
        reset = 1'b0; ds_allowin = 1'b1;
        smp();
        tests++;
        if ({dut.fs_valid_r, dut.buf_valid_r, fs_to_ds_valid, inst_sram_en, inst_sram_addr} !==
            {1'b0, 1'b0, 1'b0, 1'b1, 32'h1c00_0000}) begin
            fails++; $display("FAIL rststall_post: got fsv=%b buf=%b v=%b en=%b addr=%h",
                              dut.fs_valid_r, dut.buf_valid_r, fs_to_ds_valid,
                              inst_sram_en, inst_sram_addr);
        end
        cyc(); smp();
        end_test("reset_stall");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_bus(1'b0, 32'h1c00_0000 + 32'(4 * i)));
        smp();
        for (int i = 0; i < 8; i++) begin
            cyc(); smp();
            tests++;
            if ({inst_sram_en, fs_to_ds_valid, inst_sram_we, inst_sram_wdata,
                 inst_sram_we_b, inst_sram_wdata_b} !== {1'b1, 1'b1, 4'b0, 32'h0, 4'b0, 32'h0}) begin
                fails++; $display("FAIL b2b_%0d: got en=%b v=%b we=%h wd=%h", i,
                                  inst_sram_en, fs_to_ds_valid, inst_sram_we, inst_sram_wdata);
            end
        end
        end_test("back_to_back");
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1; ds_allowin = 1'b1; br_taken = 1'b0; flush = 1'b0;
        br_target = 32'h0; flush_target = 32'h0;
        test_reset();
        test_stall();
        test_branch();
        test_flush();
        test_align();
        test_reset_stall();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_stage_pipe.md
Name: if_stage_pipe

Overview:
- Instruction-fetch stage for the pipelined LoongArch core; successor to the single-cycle core's PC/fetch logic.
- Generates the next PC (pre-IF), issues it to a synchronous-read instruction SRAM with 1-cycle latency, and holds the fetched PC/instruction in an IF register.
- Hands off to the decode stage with a valid/allowin handshake.
- Supports branch redirect, flush redirect, a stall skid buffer and fetch-address alignment checking.

Parameters:
- RESET_PC, 32'h1c000000, PC of the first instruction fetched after reset.
- ALIGN_CHK, 1, when 1 a misaligned fetch PC raises ADEF and suppresses the SRAM access; when 0 pc[1:0] is ignored.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- ds_allowin  in  1  decode stage can accept an instruction this cycle.
- br_taken  in  1  branch redirect from ID; only asserted when ds_allowin=1.
- br_target  in  32  branch target PC.
- flush  in  1  exception/ertn redirect; highest priority.
- flush_target  in  32  redirect PC on flush.
- fs_to_ds_valid  out  1  IF holds a valid, non-cancelled instruction.
- fs_to_ds_bus  out  65  {adef, pc[31:0], inst[31:0]}.
- inst_sram_en  out  1  SRAM read enable.
- inst_sram_we  out  4  always 4'b0.
- inst_sram_addr  out  32  fetch address (nextpc).
- inst_sram_wdata  out  32  always 0.
- inst_sram_rdata  in  32  read data, valid the cycle after an enabled request.

Behaviour:
- Reset values:
  - fs_valid=0.
  - fs_pc=RESET_PC-4, so the first nextpc after reset equals RESET_PC.
  - buf_valid=0.
  - fs_to_ds_valid=0.
  - inst_sram_en=0 while reset is high.
- Pre-IF:
  - to_fs_valid = ~reset.
  - nextpc = flush ? flush_target : br_taken ? br_target : fs_pc+4 (32-bit wrap, carry dropped).
  - inst_sram_addr = nextpc.
  - pre_adef = ALIGN_CHK & (nextpc[1:0] != 0).
  - inst_sram_en = to_fs_valid & fs_allowin & ~pre_adef.
- Handshake:
  - fs_ready_go = 1.
  - fs_allowin = ~fs_valid | ds_allowin | flush.
  - fs_to_ds_valid = fs_valid & ~flush & ~br_taken (the wrong-path instruction is cancelled in the redirect cycle).
- IF register update, on fs_allowin:
  - fs_valid <= to_fs_valid.
  - fs_pc <= nextpc.
  - fs_adef <= pre_adef.
  - No update when fs_allowin=0.
- Instruction select:
  - fs_inst = fs_adef ? 32'b0 : buf_valid ? inst_buf : inst_sram_rdata.
- Skid buffer (SRAM output is not held across idle cycles):
  - Capture: when fs_valid & ~ds_allowin & ~buf_valid & ~flush, set inst_buf <= inst_sram_rdata and buf_valid <= 1.
  - Clear buf_valid on fs_allowin, flush or reset.
  - The buffer is captured only in the first stall cycle and stays stable for the rest of the stall.
- Redirect:
  - flush overrides br_taken; both in the same cycle yields nextpc = flush_target.
  - A redirect while IF is stalled is accepted only for flush; br_taken with ds_allowin=0 is a contract violation and is checked by a bench assertion.
- Reset mid-stall:
  - The next cycle returns to reset state.
  - The first fetch after release is RESET_PC.
  - The buffered instruction is discarded.
- Back-to-back: one instruction per cycle at steady state with ds_allowin=1.

Test Plan:
- Reset release with ds_allowin=1:
  - Required: inst_sram_addr sequence 0x1c000000, 0x1c000004, 0x1c000008.
  - fs_to_ds_valid rises the cycle after the first enable.
  - bus pc=0x1c000000 with the matching rdata.
- Stall 3 cycles with IF holding pc=0x1c000008, while the SRAM model drives garbage 0xdeadbeef after the first stall cycle:
  - bus inst stays at the original word.
  - inst_sram_en=0 during the stall.
  - After release, the next pc is 0x1c00000c.
- br_taken=1, br_target=0x1c000100 while IF holds 0x1c000010:
  - fs_to_ds_valid=0 that cycle.
  - inst_sram_addr=0x1c000100.
  - Next valid bus pc=0x1c000100.
- flush=1, flush_target=0x1c008000 coincident with br_taken=1 and ds_allowin=0:
  - addr=0x1c008000.
  - buf_valid cleared.
  - Next valid pc=0x1c008000.
- ALIGN_CHK=1, br_target=0x1c000102:
  - inst_sram_en=0.
  - Next bus = {adef=1, pc=0x1c000102, inst=0}.
- Repeat with ALIGN_CHK=0: adef=0 and a normal fetch occurs.
- Assert reset during a stall with buf_valid=1:
  - The following cycle has fs_valid=0 and buf_valid=0.
  - The first fetch after release is 0x1c000000.
